axi64_scratchpad_slave: RTL and testbench
=========================================

Name: axi64_scratchpad_slave

Overview:
- AXI4 responder: the opposite end of the 64-bit AXI master port that the vector unit drives.
- Backs read and write bursts with a synchronous on-chip word array.
- Used as the vector unit's local data memory in FPGA builds.
- Used as the memory model in unit-level simulation of the vector unit.

Parameters:
- DEPTH_WORDS, 4096, number of 64-bit words stored; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 8-byte aligned.
- ID_WIDTH, 6, width of arid/rid/awid/bid.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- axi64  axi64_interface.slave  n/a  AXI channels: ar*, r*, aw*, w*, b*. Address width 32, data width 64, wstrb width 8, len width 8, size width 3, burst width 2, resp width 2.

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bid=0, bresp=0. Both FSMs return to idle. Array contents are not cleared. Assertion mid-burst abandons the burst; no response is owed after reset.
- Read and write paths are independent FSMs and may be active concurrently.
- Beat address handling:
  - Beat address starts at araddr/awaddr.
  - INCR and WRAP advance the address by 2^size per beat (WRAP is treated as INCR). FIXED does not advance it.
  - Word index = (addr - BASE_ADDR) >> 3, using log2(DEPTH_WORDS) bits. Lanes are always the full 64 bits.
  - A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
- Read FSM, states R_IDLE and R_BURST:
  - R_IDLE: arready=1. On arvalid&&arready, latch id, len, size, burst and addr; issue the word read; go to R_BURST.
  - R_BURST: rvalid=1 starting the cycle after the AR handshake (1-cycle latency).
  - On each rvalid&&rready the next word is read, so back-to-back beats run with zero bubbles.
  - rdata, rid, rresp and rlast stay stable while rvalid&&!rready.
  - rlast=1 on beat len+1. Its handshake returns to R_IDLE; arready rises the following cycle.
  - Out-of-range beat: rdata=0, rresp=2'b10 (SLVERR). Otherwise rresp=2'b00.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: awready=1, wready=0. W beats are never accepted before the AW handshake.
  - W_DATA: wready=1. Each wvalid&&wready writes the bytes enabled by wstrb. Out-of-range beats are dropped and set a sticky error.
  - The beat counter, not wlast, ends the burst. After beat len+1 go to W_RESP.
  - If wlast does not match the final-beat position on any beat, set the sticky error.
  - W_RESP: bvalid=1, bid=latched awid, bresp=SLVERR if the sticky error is set, else OKAY. Values are held until bready; then go to W_IDLE and clear the error.
- Same-cycle read and write to one word: the read returns the old data; the write lands.
- Burst length: len=255 gives 256 beats; the 8-bit counter must not overflow.
- FIXED bursts repeatedly target one word; writes hit it in order and the last one wins.

Optional Feature:
- Macro AXI64_SCRATCHPAD_STALL_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1, advanced every cycle) gates the ready and valid outputs:
  - arready, awready and wready are additionally ANDed with lfsr[0].
  - R-beat presentation is deferred while lfsr[1]=1; a beat already presented stays valid until accepted.
  - This exercises master backpressure handling.
- When undefined: no LFSR exists, and the timing is exactly as specified above.

Test Plan:
- Single write then read: AW addr 0x10, len 0, wdata 64'h1122334455667788, wstrb 8'hFF. Expect bresp 0. Then AR addr 0x10, len 0: expect rdata 64'h1122334455667788, rlast=1, rresp 0, first rvalid one cycle after the AR handshake.
- INCR burst: write len 15 at addr 0x100 with data = beat index. Read back len 15 with rready held high: expect 16 consecutive beats 0..15, no bubbles, rlast only on beat 16.
- Byte strobes: word at 0x20 preset to all 1s. Write wdata 0, wstrb 8'h0F. Expect readback 64'hFFFFFFFF00000000.
- Out of range: AR at BASE_ADDR + 8*DEPTH_WORDS, len 1. Expect 2 beats with rdata 0 and rresp 2'b10. A write of len 0 there gives bresp 2'b10 and leaves the array unchanged.
- Backpressure and wlast error:
  - rready toggles 1/0: rdata stays stable while stalled.
  - A write of len 3 with wlast asserted on beat 2 gives bresp 2'b10 after the 4th beat.
- Reset mid-burst: assert rst during beat 5 of a len-15 read. rvalid drops immediately. After release, arready=1, and a new read returns the correct data.

Source files
------------

// File: rtl/axi64_scratchpad_slave_if.sv
// AXI4 channel bundle (32-bit address, 64-bit data) between the vector unit
// master port and its scratchpad responder.
interface axi64_interface #(
  parameter int unsigned ID_WIDTH = 6
);
  logic [31:0]         araddr;
  logic [ID_WIDTH-1:0] arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [63:0]         rdata;
  logic [ID_WIDTH-1:0] rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [31:0]         awaddr;
  logic [ID_WIDTH-1:0] awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rid, rresp, rlast, rvalid, output rready,
    output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rid, rresp, rlast, rvalid, input rready,
    input  awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi64_scratchpad_slave.sv
// AXI4 scratchpad responder backed by a synchronous 64-bit word array.
// Optional macro AXI64_SCRATCHPAD_STALL_EN adds LFSR-driven ready/valid stalls.
module axi64_scratchpad_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ID_WIDTH    = 6
) (
  input  logic          clk,
  input  logic          rst,
  axi64_interface.slave axi64
);
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT       = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 3);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic       {R_IDLE, R_BURST}         r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (33'(a) < LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + (32'd1 << size);
  endfunction

  // gate_c: ready permission for the next cycle; present_c: a fetched R beat may be shown
  logic gate_c, present_c;
`ifdef AXI64_SCRATCHPAD_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  assign gate_c    = lfsr_d[0];
  assign present_c = !lfsr_q[1];
`else
  assign gate_c    = 1'b1;
  assign present_c = 1'b1;
`endif

  logic [63:0] mem [DEPTH_WORDS];

  r_state_e            r_state_q, r_state_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d, rburst_q, rburst_d;
  logic [31:0]         raddr_q, raddr_d;
  logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]          rsize_q, rsize_d;
  logic [63:0]         rdata_q;
  logic                rd_en_c;
  logic [31:0]         rd_addr_c;

  w_state_e            w_state_q, w_state_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                werr_q, werr_d, w_last_beat_c, wr_en_c;
  logic [ID_WIDTH-1:0] wid_q, wid_d, bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d, wburst_q, wburst_d;
  logic [31:0]         waddr_q, waddr_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]          wsize_q, wsize_d;
  logic [IDX_W-1:0]    wr_idx_c;

  // Read path: fetch the next word on each accepted beat so beats run back to back
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rd_en_c   = 1'b0;
    rd_addr_c = raddr_q;
    unique case (r_state_q)
      R_IDLE: if (axi64.arvalid && arready_q) begin
        r_state_d = R_BURST;
        raddr_d   = axi64.araddr;
        rlen_d    = axi64.arlen;
        rsize_d   = axi64.arsize;
        rburst_d  = axi64.arburst;
        rid_d     = axi64.arid;
        rcnt_d    = 8'd0;
        rd_en_c   = 1'b1;
        rd_addr_c = axi64.araddr;
        rlast_d   = (axi64.arlen == 8'd0);
        rvalid_d  = present_c;
      end
      R_BURST: if (rvalid_q && axi64.rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end else begin
          raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
          rd_en_c   = 1'b1;
          rd_addr_c = raddr_d;
          rcnt_d    = 8'(rcnt_q + 8'd1);
          rlast_d   = (rcnt_d == rlen_q);
          rvalid_d  = present_c;
        end
      end else if (!rvalid_q) begin
        rvalid_d = present_c;
      end
    endcase
    if (rd_en_c) rresp_d = in_range(rd_addr_c) ? RESP_OKAY : RESP_SLVERR;
    arready_d = (r_state_d == R_IDLE) && gate_c;
  end

  // Write path: the beat counter, not wlast, closes the burst
  always_comb begin
    w_state_d     = w_state_q;
    bvalid_d      = bvalid_q;
    bid_d         = bid_q;
    bresp_d       = bresp_q;
    wid_d         = wid_q;
    waddr_d       = waddr_q;
    wlen_d        = wlen_q;
    wsize_d       = wsize_q;
    wburst_d      = wburst_q;
    wcnt_d        = wcnt_q;
    werr_d        = werr_q;
    wr_en_c       = 1'b0;
    wr_idx_c      = word_idx(waddr_q);
    w_last_beat_c = (wcnt_q == wlen_q);
    unique case (w_state_q)
      W_IDLE: if (axi64.awvalid && awready_q) begin
        w_state_d = W_DATA;
        wid_d     = axi64.awid;
        waddr_d   = axi64.awaddr;
        wlen_d    = axi64.awlen;
        wsize_d   = axi64.awsize;
        wburst_d  = axi64.awburst;
        wcnt_d    = 8'd0;
        werr_d    = 1'b0;
      end
      W_DATA: if (axi64.wvalid && wready_q) begin
        wr_en_c = in_range(waddr_q);
        if (!in_range(waddr_q) || (axi64.wlast != w_last_beat_c)) werr_d = 1'b1;
        if (w_last_beat_c) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bid_d     = wid_q;
          bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
        end else begin
          waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
          wcnt_d  = 8'(wcnt_q + 8'd1);
        end
      end
      W_RESP: if (bvalid_q && axi64.bready) begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
        werr_d    = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && gate_c;
    wready_d  = (w_state_d == W_DATA) && gate_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  // Synchronous array read; out-of-range beats return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata_q <= '0;
    else if (rd_en_c) rdata_q <= in_range(rd_addr_c) ? mem[word_idx(rd_addr_c)] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 8; b++) begin
        if (axi64.wstrb[b]) mem[wr_idx_c][b*8 +: 8] <= axi64.wdata[b*8 +: 8];
      end
    end
  end

  assign axi64.arready = arready_q;
  assign axi64.rvalid  = rvalid_q;
  assign axi64.rlast   = rlast_q;
  assign axi64.rid     = rid_q;
  assign axi64.rresp   = rresp_q;
  assign axi64.rdata   = rdata_q;
  assign axi64.awready = awready_q;
  assign axi64.wready  = wready_q;
  assign axi64.bvalid  = bvalid_q;
  assign axi64.bid     = bid_q;
  assign axi64.bresp   = bresp_q;
endmodule

// File: tb/tb_axi64_scratchpad_slave.sv
// Directed self-checking bench for axi64_scratchpad_slave (default build, no stalls).
module tb_axi64_scratchpad_slave;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic clk, rst;
  int   n_assert, n_fail;

  logic [63:0] wbuf [256];
  logic [63:0] rbuf [256];
  logic [1:0]  rresp_buf [256];
  logic        rlast_buf [256];
  int          r_beats, r_bubbles, last_cnt;
  logic [1:0]  b_resp;
  logic [5:0]  b_id, r_id_first;

  axi64_interface #(.ID_WIDTH(6)) bus ();

  axi64_scratchpad_slave #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h0000_0000),
    .ID_WIDTH   (6)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .axi64(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] id, input logic [7:0] strb, input int wlast_at);
    int t;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = 3'd3;
    bus.awburst = burst;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("aw_timeout", 64'(bus.awready), 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = wbuf[i];
      bus.wstrb  = strb;
      bus.wlast  = (i == wlast_at);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin chk("w_timeout", 64'(bus.wready), 64'd1); break; end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("b_timeout", 64'(bus.bvalid), 64'd1);
    b_resp = bus.bresp;
    b_id   = bus.bid;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [5:0] id, input logic toggle);
    int t, k;
    logic prev_stall, rr;
    logic [63:0] prev_data;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = 3'd3;
    bus.arburst = burst;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("ar_timeout", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    r_beats = 0; r_bubbles = 0; prev_stall = 1'b0; prev_data = '0; k = 0;
    while (r_beats <= int'(len) && k < 4000) begin
      rr = toggle ? k[0] : 1'b1;
      bus.rready = rr;
      if (bus.rvalid) begin
        if (prev_stall) chk("r_stall_hold", bus.rdata, prev_data);
        if (r_beats == 0) r_id_first = bus.rid;
        if (rr) begin
          rbuf[r_beats]      = bus.rdata;
          rresp_buf[r_beats] = bus.rresp;
          rlast_buf[r_beats] = bus.rlast;
          r_beats++;
        end
        prev_stall = !rr;
        prev_data  = bus.rdata;
      end else begin
        prev_stall = 1'b0;
        r_bubbles++;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.rready = 1'b0;
    chk("r_beat_count", 64'(r_beats), 64'(int'(len) + 1));
  endtask

  initial begin
    int t, k;
    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_rlast",   64'(bus.rlast),   64'd0);
    chk("rst_rid",     64'(bus.rid),     64'd0);
    chk("rst_rdata",   bus.rdata,        64'd0);
    chk("rst_rresp",   64'(bus.rresp),   64'd0);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_bid",     64'(bus.bid),     64'd0);
    chk("rst_bresp",   64'(bus.bresp),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_arready", 64'(bus.arready), 64'd1);
    chk("idle_awready", 64'(bus.awready), 64'd1);
    chk("idle_wready",  64'(bus.wready),  64'd0);

    // Single write then read
    wbuf[0] = 64'h1122334455667788;
    do_write(32'h10, 8'd0, INCR, 6'h2A, 8'hFF, 0);
    chk("single_bresp", 64'(b_resp), 64'd0);
    chk("single_bid",   64'(b_id),   64'h2A);
    do_read(32'h10, 8'd0, INCR, 6'h15, 1'b0);
    chk("single_rdata",   rbuf[0],              64'h1122334455667788);
    chk("single_rlast",   64'(rlast_buf[0]),    64'd1);
    chk("single_rresp",   64'(rresp_buf[0]),    64'd0);
    chk("single_rid",     64'(r_id_first),      64'h15);
    chk("single_latency", 64'(r_bubbles),       64'd0);

    // INCR burst of 16
    for (int i = 0; i < 16; i++) wbuf[i] = 64'(i);
    do_write(32'h100, 8'd15, INCR, 6'h01, 8'hFF, 15);
    chk("incr_bresp", 64'(b_resp), 64'd0);
    do_read(32'h100, 8'd15, INCR, 6'h02, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("incr_rdata", rbuf[i], 64'(i));
      chk("incr_rlast", 64'(rlast_buf[i]), 64'(i == 15));
    end
    chk("incr_bubbles", 64'(r_bubbles), 64'd0);

    // Byte strobes
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h20, 8'd0, INCR, 6'h03, 8'hFF, 0);
    wbuf[0] = 64'd0;
    do_write(32'h20, 8'd0, INCR, 6'h03, 8'h0F, 0);
    chk("strb_bresp", 64'(b_resp), 64'd0);
    do_read(32'h20, 8'd0, INCR, 6'h04, 1'b0);
    chk("strb_rdata", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // Out of range, and the last in-range word
    wbuf[0] = 64'hDEAD_BEEF_CAFE_F00D;
    do_write(32'h0, 8'd0, INCR, 6'h05, 8'hFF, 0);
    do_read(32'h8000, 8'd1, INCR, 6'h06, 1'b0);
    chk("oob_rdata0", rbuf[0], 64'd0);
    chk("oob_rdata1", rbuf[1], 64'd0);
    chk("oob_rresp0", 64'(rresp_buf[0]), 64'd2);
    chk("oob_rresp1", 64'(rresp_buf[1]), 64'd2);
    chk("oob_rlast0", 64'(rlast_buf[0]), 64'd0);
    chk("oob_rlast1", 64'(rlast_buf[1]), 64'd1);
    wbuf[0] = 64'h5555_5555_5555_5555;
    do_write(32'h8000, 8'd0, INCR, 6'h07, 8'hFF, 0);
    chk("oob_bresp", 64'(b_resp), 64'd2);
    do_read(32'h0, 8'd0, INCR, 6'h08, 1'b0);
    chk("oob_unchanged", rbuf[0], 64'hDEAD_BEEF_CAFE_F00D);
    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    do_write(32'h7FF8, 8'd0, INCR, 6'h09, 8'hFF, 0);
    chk("top_bresp", 64'(b_resp), 64'd0);
    do_read(32'h7FF8, 8'd0, INCR, 6'h0A, 1'b0);
    chk("top_rdata", rbuf[0], 64'h0123_4567_89AB_CDEF);
    chk("top_rresp", 64'(rresp_buf[0]), 64'd0);

    // R backpressure: rready toggling
    do_read(32'h100, 8'd15, INCR, 6'h0B, 1'b1);
    for (int i = 0; i < 16; i++) chk("bp_rdata", rbuf[i], 64'(i));
    chk("bp_rlast", 64'(rlast_buf[15]), 64'd1);

    // Misplaced wlast: burst still runs 4 beats, error response
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
    do_write(32'h200, 8'd3, INCR, 6'h0C, 8'hFF, 1);
    chk("wlast_bresp", 64'(b_resp), 64'd2);
    chk("wlast_bid",   64'(b_id),   64'h0C);
    wbuf[0] = 64'h77;
    do_write(32'h300, 8'd0, INCR, 6'h0D, 8'hFF, 0);
    chk("err_cleared_bresp", 64'(b_resp), 64'd0);

    // FIXED bursts target one word; last write wins
    wbuf[0] = 64'h111; wbuf[1] = 64'h222; wbuf[2] = 64'h333;
    do_write(32'h40, 8'd2, FIXED, 6'h0E, 8'hFF, 2);
    chk("fixed_bresp", 64'(b_resp), 64'd0);
    do_read(32'h40, 8'd1, FIXED, 6'h0F, 1'b0);
    chk("fixed_rdata0", rbuf[0], 64'h333);
    chk("fixed_rdata1", rbuf[1], 64'h333);

    // Maximum length burst
    for (int i = 0; i < 256; i++) wbuf[i] = {32'hC0DE_0000, 32'(i)};
    do_write(32'h1000, 8'd255, INCR, 6'h10, 8'hFF, 255);
    chk("max_bresp", 64'(b_resp), 64'd0);
    do_read(32'h1000, 8'd255, INCR, 6'h11, 1'b0);
    last_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      chk("max_rdata", rbuf[i], {32'hC0DE_0000, 32'(i)});
      if (rlast_buf[i]) last_cnt++;
    end
    chk("max_rlast_count", 64'(last_cnt), 64'd1);
    chk("max_rlast_final", 64'(rlast_buf[255]), 64'd1);
    chk("max_bubbles", 64'(r_bubbles), 64'd0);

    // Reset during beat 5 of a 16-beat read
    bus.araddr = 32'h100; bus.arlen = 8'd15; bus.arsize = 3'd3; bus.arburst = INCR;
    bus.arid = 6'h12; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 200) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    k = 0; t = 0;
    while (k < 4 && t < 100) begin
      if (bus.rvalid) k++;
      @(posedge clk); #1;
      t++;
    end
    chk("rstmid_beat5", bus.rdata, 64'd4);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rstmid_arready", 64'(bus.arready), 64'd0);
    bus.rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_arready_after", 64'(bus.arready), 64'd1);
    chk("rstmid_bvalid",        64'(bus.bvalid),  64'd0);
    do_read(32'h128, 8'd0, INCR, 6'h13, 1'b0);
    chk("rstmid_readback", rbuf[0], 64'd5);
    chk("rstmid_rresp",    64'(rresp_buf[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
